// File: rtl/uart_rx_fifo.sv
//-----------------------------------------------------------------------------
// uart_rx_fifo
// 8N1 UART receiver with 16x oversampling that feeds a FIFO_DEPTH-entry frame
// buffer. The whole buffer is presented in parallel so the sweeper can latch
// a complete command, and a single fifo_rd_en pulse consumes the frame.
//
// Ports:
//   clk_50m          in   system clock, rising edge
//   reset            in   asynchronous active-low reset
//   rx               in   serial input, idle high
//   fifo_rd_en       in   frame consume pulse (clears the whole buffer)
//   fifo_data_out    out  buffer image, entry k at [FIFO_WIDTH*k +: FIFO_WIDTH]
//   fifo_empty       out  count == 0
//   fifo_full        out  count == FIFO_DEPTH
//   fifo_almost_full out  count >= FIFO_DEPTH-1
//   frame_err        out  (UART_RX_FRAME_ERR_EN only) one-cycle bad-stop pulse
//
// Optional feature macro: UART_RX_FRAME_ERR_EN
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned UART_BAUD  = 115200,
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 11
) (
  input  logic                             clk_50m,
  input  logic                             reset,
  input  logic                             rx,
  input  logic                             fifo_rd_en,
  output logic [FIFO_WIDTH*FIFO_DEPTH-1:0] fifo_data_out,
  output logic                             fifo_empty,
  output logic                             fifo_full,
  output logic                             fifo_almost_full
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic                             frame_err
`endif
);

  localparam int unsigned DIV   = CLK_FREQ / (UART_BAUD * 16);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BUF_W = FIFO_WIDTH * FIFO_DEPTH;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Baud x16 tick generator
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_baud_tick;

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      r_div_cnt   <= '0;
      r_baud_tick <= 1'b0;
    end else if (r_div_cnt == DIV_W'(DIV - 1)) begin
      r_div_cnt   <= '0;
      r_baud_tick <= 1'b1;
    end else begin
      r_div_cnt   <= r_div_cnt + DIV_W'(1);
      r_baud_tick <= 1'b0;
    end
  end

  // Two-flop synchronizer plus one history flop for falling-edge detection
  logic r_rx_meta, r_rx_sync, r_rx_prev;
  logic w_rx_fall;

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;

  // Receiver FSM: state and datapath registers
  state_t     r_state, w_state_nxt;
  logic [3:0] r_tick_cnt, w_tick_nxt;
  logic [2:0] r_bit_cnt, w_bit_nxt;
  logic [7:0] uart_data, w_data_nxt;
  logic       fifo_wr_en, w_wr_nxt;
`ifdef UART_RX_FRAME_ERR_EN
  logic       r_frame_err, w_ferr_nxt;
`endif

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      uart_data  <= '0;
      fifo_wr_en <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      r_frame_err <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      uart_data  <= w_data_nxt;
      fifo_wr_en <= w_wr_nxt;
`ifdef UART_RX_FRAME_ERR_EN
      r_frame_err <= w_ferr_nxt;
`endif
    end
  end

  // Next-state logic; samples land mid-bit (8 ticks into start, then every 16)
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_data_nxt  = uart_data;
    w_wr_nxt    = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    w_ferr_nxt  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_rx_fall) begin
          w_state_nxt = S_START;
          w_tick_nxt  = '0;
        end
      end
      S_START: begin
        if (r_baud_tick) begin
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd7) begin
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
            // A high line at mid-start is a glitch, not a start bit
            w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (r_baud_tick) begin
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            w_data_nxt = {r_rx_sync, uart_data[7:1]};
            w_bit_nxt  = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_state_nxt = S_STOP;
            end
          end
        end
      end
      S_STOP: begin
        if (r_baud_tick) begin
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            w_state_nxt = S_IDLE;
            w_wr_nxt    = r_rx_sync;
`ifdef UART_RX_FRAME_ERR_EN
            w_ferr_nxt  = ~r_rx_sync;
`endif
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame buffer: a read clears everything, then a same-cycle write lands at 0
  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             w_full_int;
  logic             w_wr_ok;

  assign w_full_int = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_wr_ok    = fifo_wr_en & ~w_full_int;

  always_comb begin
    w_count_nxt = r_count;
    if (fifo_rd_en) begin
      w_count_nxt = fifo_wr_en ? CNT_W'(1) : '0;
    end else if (w_wr_ok) begin
      w_count_nxt = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      r_buf   <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (fifo_rd_en) begin
        r_buf <= '0;
        if (fifo_wr_en) begin
          r_buf[FIFO_WIDTH-1:0] <= FIFO_WIDTH'(uart_data);
        end
      end else if (w_wr_ok) begin
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
          if (r_count == CNT_W'(i)) begin
            r_buf[FIFO_WIDTH*i +: FIFO_WIDTH] <= FIFO_WIDTH'(uart_data);
          end
        end
      end
    end
  end

  // Registered status flags derived from the post-edge count
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      fifo_empty       <= 1'b1;
      fifo_full        <= 1'b0;
      fifo_almost_full <= 1'b0;
    end else begin
      fifo_empty       <= (w_count_nxt == '0);
      fifo_full        <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
      fifo_almost_full <= (w_count_nxt >= CNT_W'(FIFO_DEPTH - 1));
    end
  end

  assign fifo_data_out = r_buf;

`ifdef UART_RX_FRAME_ERR_EN
  // Sticky record that a completed byte was dropped on a full buffer
  logic overflow_seen;

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      overflow_seen <= 1'b0;
    end else if (fifo_wr_en && w_full_int && !fifo_rd_en) begin
      overflow_seen <= 1'b1;
    end
  end

  assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
//-----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Drives serial frames into uart_rx_fifo and compares the buffer image and
// flags against a queue-based model of the frame buffer. The baud rate is
// raised (divider of 4) so that a full command frame fits in a short run;
// the glitch length is scaled to stay below half a bit period.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int unsigned FW      = 8;
  localparam int unsigned FD      = 11;
  localparam int unsigned IMG_W   = FW * FD;
  localparam int unsigned BIT_CYC = 64;   // 16 ticks x divider 4

  logic             clk_50m = 1'b0;
  logic             reset;
  logic             rx;
  logic             fifo_rd_en;
  logic [IMG_W-1:0] fifo_data_out;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_almost_full;

  int unsigned errors    = 0;
  int unsigned checks    = 0;
  int unsigned wr_pulses = 0;
  logic [7:0]  last_data = 8'h00;
  logic [7:0]  mq[$];

  uart_rx_fifo #(
    .CLK_FREQ  (50000000),
    .UART_BAUD (781250),
    .FIFO_WIDTH(FW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk_50m         (clk_50m),
    .reset           (reset),
    .rx              (rx),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_data_out   (fifo_data_out),
    .fifo_empty      (fifo_empty),
    .fifo_full       (fifo_full),
    .fifo_almost_full(fifo_almost_full)
  );

  always #10 clk_50m = ~clk_50m;

  // Monitor of the receiver's write strobe and the byte it carries
  always @(posedge clk_50m) begin
    if (dut.fifo_wr_en === 1'b1) begin
      wr_pulses <= wr_pulses + 1;
      last_data <= dut.uart_data;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [IMG_W-1:0] obs, input logic [IMG_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [IMG_W-1:0] model_img();
    logic [IMG_W-1:0] img;
    img = '0;
    foreach (mq[i]) img[FW*i +: FW] = mq[i];
    return img;
  endfunction

  function automatic logic [2:0] model_flags();
    int unsigned n;
    n = mq.size();
    return {n == 0, n == FD, n >= FD - 1};
  endfunction

  task automatic model_write(input logic [7:0] b);
    if (mq.size() < FD) mq.push_back(b);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_img"}, fifo_data_out, model_img());
    chk({tag, "_flags"}, IMG_W'({fifo_empty, fifo_full, fifo_almost_full}), IMG_W'(model_flags()));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(BIT_CYC);
    end
    rx = stop_bit;
    cyc(BIT_CYC);
    rx = 1'b1;
    cyc(16);
  endtask

  task automatic pulse_rd();
    fifo_rd_en = 1'b1;
    cyc(1);
    fifo_rd_en = 1'b0;
    mq.delete();
  endtask

  logic [7:0]  cmd[FD] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h64, 8'h00,
                           8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
  logic [IMG_W-1:0] cmd_img = 88'h00_0000FFFF_0064_000000FF;
  logic [IMG_W-1:0] a5_img  = 88'hA5;
  logic [IMG_W-1:0] b81_img = 88'h81;
  int unsigned p;
  logic        got;
  logic [7:0]  b;
  logic [7:0]  part;

  initial begin
    reset = 1'b0;
    rx = 1'b1;
    fifo_rd_en = 1'b0;
    cyc(5);
    chk_state("reset_low");
    reset = 1'b1;
    cyc(5);
    chk_state("reset_rel");

    // Single byte
    p = wr_pulses;
    send_byte(8'hA5, 1'b1);
    model_write(8'hA5);
    chk("a5_pulses", IMG_W'(wr_pulses - p), IMG_W'(1));
    chk("a5_uart_data", IMG_W'(last_data), IMG_W'(8'hA5));
    chk("a5_fixed_img", fifo_data_out, a5_img);
    chk_state("a5");
    pulse_rd();
    chk_state("rd_a5");

    // Full 11-byte command
    for (int k = 0; k < FD; k++) begin
      send_byte(cmd[k], 1'b1);
      model_write(cmd[k]);
      chk_state($sformatf("cmd%0d", k));
    end
    chk("cmd_fixed_img", fifo_data_out, cmd_img);

    // Overflow byte is received but dropped
    p = wr_pulses;
    send_byte(8'h55, 1'b1);
    model_write(8'h55);
    chk("ovf_pulses", IMG_W'(wr_pulses - p), IMG_W'(1));
    chk_state("ovf");
    pulse_rd();
    chk_state("rd_full");
    chk("rd_full_empty", IMG_W'(fifo_empty), IMG_W'(1'b1));

    // Bad stop bit
    p = wr_pulses;
    send_byte(8'h3C, 1'b0);
    chk("bad_stop_pulses", IMG_W'(wr_pulses - p), IMG_W'(0));
    chk_state("bad_stop");

    // Short low glitch shorter than half a bit
    p = wr_pulses;
    rx = 1'b0;
    cyc(20);
    rx = 1'b1;
    cyc(BIT_CYC * 11);
    chk("glitch_pulses", IMG_W'(wr_pulses - p), IMG_W'(0));
    chk_state("glitch");

    // Reset during the 4th data bit, then a clean byte
    send_byte(8'h11, 1'b1);
    model_write(8'h11);
    p = wr_pulses;
    part = 8'h5A;
    rx = 1'b0;
    cyc(BIT_CYC);
    for (int i = 0; i < 3; i++) begin
      rx = part[i];
      cyc(BIT_CYC);
    end
    rx = part[3];
    cyc(BIT_CYC / 2);
    reset = 1'b0;
    mq.delete();
    cyc(2);
    rx = 1'b1;
    cyc(5);
    reset = 1'b1;
    cyc(BIT_CYC * 11);
    chk("midrst_pulses", IMG_W'(wr_pulses - p), IMG_W'(0));
    chk_state("midrst");
    send_byte(8'h81, 1'b1);
    model_write(8'h81);
    chk("b81_fixed_img", fifo_data_out, b81_img);
    chk_state("b81");

    // Randomized mix of writes, reads and read-during-write
    for (int it = 0; it < 16; it++) begin
      b = 8'($urandom);
      case ($urandom_range(0, 5))
        0: pulse_rd();
        1: begin
          got = 1'b0;
          fork
            send_byte(b, 1'b1);
            begin
              for (int c = 0; c < int'(BIT_CYC) * 12 && !got; c++) begin
                cyc(1);
                if (dut.fifo_wr_en === 1'b1) got = 1'b1;
              end
              if (got) begin
                fifo_rd_en = 1'b1;
                cyc(1);
                fifo_rd_en = 1'b0;
              end
            end
          join
          chk($sformatf("rnd%0d_wr_seen", it), IMG_W'(got), IMG_W'(1'b1));
          mq.delete();
          mq.push_back(b);
        end
        default: begin
          send_byte(b, 1'b1);
          model_write(b);
        end
      endcase
      chk_state($sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
